sdram_arbiter: RTL
==================

Name: sdram_arbiter

Overview:
Round-robin arbiter that shares the single SDRAM system request interface among up to four bus masters (CPU, PPU, APU/DMA, debug).
- Selects one pending requester and registers its address, data and direction onto the shared request bus, tagging it with the requester index as req_id.
- Holds the grant until the command generator pulses req_ack, then returns a one-cycle ack to the winner.
- Sits between the system-bus masters and the SDRAM command generator.

Parameters:
AN, 24, address bus width (bank 2b + row 13b + column 9b)
DN, 16, data bus width
N, 4, number of requesters; must be ≤ 2**IDW
IDW, 2, width of req_id
HIPRI, 0, 1 = requester 0 has fixed top priority over the rotation; 0 = pure round-robin

Ports:
clkSYS  in  1  system clock
n_reset  in  1  asynchronous active-low reset
m_req  in  N  per-requester request, level, held until m_ack
m_wr  in  N  per-requester 1 = write, 0 = read
m_addr  in  N x AN  per-requester address (unpacked array [N])
m_data  in  N x DN  per-requester write data (unpacked array [N])
m_ack  out  N  one-hot, one-cycle acknowledge to the granted requester
req  out  1  shared request to command generator
req_wr  out  1  shared write flag
req_addr  out  AN  shared address
req_data  out  DN  shared write data
req_id  out  IDW  index of the granted requester
req_ack  in  1  one-cycle acknowledge from command generator

Behaviour:
- Reset values: req=0, req_wr=0, req_addr=0, req_data=0, req_id=0, m_ack=0, FSM=Idle, rotation pointer ptr=0.
- Requester protocol: a requester asserts m_req with stable m_wr/m_addr/m_data until it sees m_ack. In the cycle after m_ack it may drop m_req or present a new request.
- Selection (combinational, in Idle only):
  - Search starts at ptr and wraps modulo N; the first set m_req bit wins.
  - If HIPRI=1 and m_req[0]=1, requester 0 wins regardless of ptr.
- FSM states:
  - Idle → Grant when any m_req is set. On that edge, register winner g: req<=1, req_id<=g, and req_wr/req_addr/req_data <= m_wr[g]/m_addr[g]/m_data[g].
  - Grant: outputs frozen; requester inputs are ignored even if they change. On req_ack=1: req<=0, m_ack[g]<=1 (one cycle), ptr <= (g+1) mod N, → Release.
  - Release: one cycle with req=0, m_ack cleared → Idle.
    - This guarantees req stays low at least one cycle after req_ack, so the command generator's Idle state never re-accepts a retired request.
    - It also lets the acked master update its inputs before the next selection.
- Latency:
  - m_req rising to req high: 1 cycle.
  - req_ack to m_ack: 1 cycle.
  - Minimum spacing between two grants: 3 cycles (Grant, Release, Idle).
- req_ack while not in Grant: ignored, no m_ack generated.
- A requester dropping m_req during Grant is a protocol violation; the request still completes and m_ack is still pulsed.
- All N requests simultaneous: served in order ptr, ptr+1, … with no requester waiting more than N grants (HIPRI=0).
- N < 2**IDW: unused req_id values are never issued. Unused inputs are tied 0.
- Reset mid-Grant: all outputs return to reset values immediately (asynchronous); the pending request is lost and the master must re-request.
- Output data fields are registered only on grant. They hold their last value otherwise and are not forced to x.

Decomposition:
- Shared package sdram_types gains:
  - localparam SDRAM_NREQ = 4.
  - typedef sdram_req_t {wr; addr[AN]; data[DN]} for one requester bundle; m_wr/m_addr/m_data may be carried as sdram_req_t [N].
  - enum arb_state_t {ArbIdle, ArbGrant, ArbRelease}.
- One sub-module: rr_pick, a combinational round-robin priority picker.
  - Inputs: req vector, ptr, hipri. Outputs: valid, index.
  - Testable standalone.

Test Plan:
1. Single request: m_req=4'b0100, m_addr[2]=24'h12_3456, m_wr[2]=0 → next cycle req=1, req_id=2, req_addr=24'h123456. Drive req_ack after 5 cycles → m_ack=4'b0100 one cycle later, req=0, ptr=3.
2. All four requesting from reset (ptr=0), req_ack each grant → req_id sequence 0,1,2,3,0; each m_ack one-hot; grants spaced ≥3 cycles.
3. HIPRI=1, m_req=4'b1111 continuously held → requester 0 wins every arbitration; with m_req=4'b1110 → order 1,2,3.
4. Write path: m_wr[1]=1, m_data[1]=16'hBEEF, change m_data[1] to 16'h0000 during Grant → req_data stays 16'hBEEF until ack.
5. Spurious req_ack in Idle and in Release → m_ack stays 0, FSM unchanged.
6. Assert n_reset low mid-Grant (req=1, req_id=3) → req=0, req_id=0, m_ack=0, ptr=0 asynchronously. After release, a pending m_req=4'b1000 is re-granted within 1 cycle.

Source files
------------

// File: rtl/sdram_types.sv
// rtl/sdram_types.sv - shared SDRAM request types and arbiter state encoding
package sdram_types;

    localparam int SDRAM_NREQ = 4;
    localparam int SDRAM_AN   = 24;
    localparam int SDRAM_DN   = 16;

    typedef struct packed {
        logic                wr;
        logic [SDRAM_AN-1:0] addr;
        logic [SDRAM_DN-1:0] data;
    } sdram_req_t;

    typedef enum logic [1:0] {
        ArbIdle,
        ArbGrant,
        ArbRelease
    } arb_state_t;

endpackage

// File: rtl/sdram_arbiter_rr_pick.sv
// rtl/sdram_arbiter_rr_pick.sv - combinational round-robin picker with optional fixed priority for requester 0
module rr_pick #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   req_i,
    input  logic [IDW-1:0] ptr_i,
    input  logic           hipri_i,
    output logic           valid_o,
    output logic [IDW-1:0] index_o
);

    logic [IDW-1:0] j;

    // Walk the rotation backwards so the last hit written is the one nearest ptr.
    always_comb begin
        valid_o = |req_i;
        index_o = '0;
        j       = '0;
        for (int i = N - 1; i >= 0; i--) begin
            j = IDW'((int'(ptr_i) + i) % N);
            if (req_i[j]) begin
                index_o = j;
            end
        end
        if (hipri_i && req_i[0]) begin
            index_o = '0;
        end
    end

endmodule

// File: rtl/sdram_arbiter.sv
// rtl/sdram_arbiter.sv - round-robin arbiter sharing the SDRAM request interface among bus masters
module sdram_arbiter
    import sdram_types::*;
#(
    parameter int AN    = 24,
    parameter int DN    = 16,
    parameter int N     = SDRAM_NREQ,
    parameter int IDW   = 2,
    parameter bit HIPRI = 1'b0
) (
    input  logic           clkSYS,
    input  logic           n_reset,
    input  logic [N-1:0]   m_req,
    input  logic [N-1:0]   m_wr,
    input  logic [AN-1:0]  m_addr [N],
    input  logic [DN-1:0]  m_data [N],
    output logic [N-1:0]   m_ack,
    output logic           req,
    output logic           req_wr,
    output logic [AN-1:0]  req_addr,
    output logic [DN-1:0]  req_data,
    output logic [IDW-1:0] req_id,
    input  logic           req_ack
);

    arb_state_t     state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic           req_q, req_d;
    logic           req_wr_q, req_wr_d;
    logic [AN-1:0]  req_addr_q, req_addr_d;
    logic [DN-1:0]  req_data_q, req_data_d;
    logic [IDW-1:0] req_id_q, req_id_d;
    logic [N-1:0]   m_ack_q, m_ack_d;

    logic           pick_valid;
    logic [IDW-1:0] pick_idx;

    rr_pick #(
        .N   (N),
        .IDW (IDW)
    ) u_pick (
        .req_i   (m_req),
        .ptr_i   (ptr_q),
        .hipri_i (HIPRI),
        .valid_o (pick_valid),
        .index_o (pick_idx)
    );

    always_ff @(posedge clkSYS or negedge n_reset) begin
        if (!n_reset) begin
            state_q    <= ArbIdle;
            ptr_q      <= '0;
            req_q      <= 1'b0;
            req_wr_q   <= 1'b0;
            req_addr_q <= '0;
            req_data_q <= '0;
            req_id_q   <= '0;
            m_ack_q    <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            req_q      <= req_d;
            req_wr_q   <= req_wr_d;
            req_addr_q <= req_addr_d;
            req_data_q <= req_data_d;
            req_id_q   <= req_id_d;
            m_ack_q    <= m_ack_d;
        end
    end

    // The data fields only load on a grant; elsewhere they keep their last value.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        req_d      = req_q;
        req_wr_d   = req_wr_q;
        req_addr_d = req_addr_q;
        req_data_d = req_data_q;
        req_id_d   = req_id_q;
        m_ack_d    = '0;
        case (state_q)
            ArbIdle: begin
                if (pick_valid) begin
                    req_d      = 1'b1;
                    req_id_d   = pick_idx;
                    req_wr_d   = m_wr[pick_idx];
                    req_addr_d = m_addr[pick_idx];
                    req_data_d = m_data[pick_idx];
                    state_d    = ArbGrant;
                end
            end
            ArbGrant: begin
                if (req_ack) begin
                    req_d             = 1'b0;
                    m_ack_d[req_id_q] = 1'b1;
                    ptr_d             = (int'(req_id_q) == N - 1) ? '0 : req_id_q + IDW'(1);
                    state_d           = ArbRelease;
                end
            end
            default: begin
                state_d = ArbIdle;
            end
        endcase
    end

    assign req      = req_q;
    assign req_wr   = req_wr_q;
    assign req_addr = req_addr_q;
    assign req_data = req_data_q;
    assign req_id   = req_id_q;
    assign m_ack    = m_ack_q;

endmodule
